alu_rr_scheduler_1210733: RTL and testbench
===========================================

# alu_rr_scheduler_1210733

Round-robin scheduler that shares one instance of the team's structural ALU (`ALU_structural_1210733`) between two independent requesters, A and B. Each requester submits an operand pair and an opcode over a valid/ready handshake. The scheduler grants one request at a time and latches the operands into the ALU. It registers the ALU result and returns it on a single response channel tagged with the requester ID. It sits between the operand producers and the result consumer as the only path into the shared ALU.

## Interface
- `n`, default 4: operand width; passed to the ALU; result width is n+2.
- `CLK` in 1: the single clock; all state updates on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `A_VALID` in 1: requester A presents a request.
- `A_X`, `A_Y` in n: signed operands from A.
- `A_SEL` in 3: ALU opcode from A.
- `A_READY` out 1: A's request is accepted this cycle.
- `B_VALID`, `B_X`, `B_Y`, `B_SEL`, `B_READY`: same as A, for requester B.
- `RESP_VALID` out 1: a result is presented.
- `RESP_ID` out 1: requester tag, 0 = A, 1 = B.
- `RESP_OUT` out n+2: signed ALU result.
- `RESP_READY` in 1: the consumer accepts the result.
- `OPS_A`, `OPS_B` out 8: count of completed responses per requester; wrap 255 -> 0.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Arbitrates between the requesters.
  - `PRIO` is a 1-bit register; reset value 0 (A favoured).
  - If only one requester is valid, it wins. If both are valid, the requester indicated by `PRIO` wins.
  - `A_READY`/`B_READY` are combinational. A ready asserts only in IDLE, only for the winner, and only when that winner's VALID is high.
  - On a handshake (VALID & READY at the edge), the scheduler latches X, Y, SEL and the winner ID into the operand registers, then moves to EXEC.
  - With no valid request it stays in IDLE.
- **EXEC**
  - The latched operands drive the ALU instance combinationally.
  - At the edge, the scheduler registers the ALU OUT into `RESP_OUT` and the latched ID into `RESP_ID`, sets `RESP_VALID`=1, and moves to RESP.
- **RESP**
  - `RESP_VALID`, `RESP_OUT` and `RESP_ID` hold stable until `RESP_READY` is sampled high.
  - On that handshake:
    - `RESP_VALID` goes to 0.
    - The `OPS_x` counter for `RESP_ID` increments.
    - `PRIO` becomes `~RESP_ID` (the served requester drops to low priority).
    - The FSM returns to IDLE.
- Arithmetic is defined entirely by the ALU; the scheduler does not widen, truncate or sign-adjust OUT.
- SEL codes:
  - 0: (X+Y)/2
  - 1: 2*(X+Y)
  - 2: X/2+Y
  - 3: X−Y/2
  - 4: NAND
  - 5: NOT X
  - 6: NOR
  - 7: XOR
- Requests are never dropped. A requester whose VALID stays high is served within one other transaction.
- VALID may deassert before acceptance without effect. The operands are sampled only at the handshake edge.
- Changes to the A/B inputs during EXEC/RESP have no effect on the transaction in flight.

## Timing
- Reset values:
  - FSM = IDLE, `PRIO`=0.
  - `RESP_VALID`=0, `RESP_ID`=0, `RESP_OUT`=0.
  - `OPS_A`=`OPS_B`=0.
  - Operand registers = 0.
  - `A_READY`/`B_READY` = 0 during the reset cycle.
- Latency:
  - Request handshake at edge t: `RESP_VALID` is high after edge t+1.
  - With `RESP_READY` held high, the response handshake is at edge t+2 and the next request handshake is at edge t+3 at the earliest.
- Throughput: at most one operation per 3 cycles.
- Backpressure: with `RESP_READY` low, the FSM stays in RESP indefinitely and both READYs stay 0.
- Simultaneous valid: the tie is broken by `PRIO`. A and B with both VALIDs high continuously strictly alternate, A first after reset.
- Counter wrap: `OPS_x`=255 followed by a completion gives 0, with no flag.
- `RST` asserted in any state returns all registers to their reset values at that edge. Any in-flight request and response are discarded without a handshake and without a counter update.

## Test plan
- Single request, n=4: A_SEL=1, A_X=3, A_Y=2, `RESP_READY`=1 -> `A_READY` high in the cycle of the request; after the next edge `RESP_VALID`=1, `RESP_OUT`=10, `RESP_ID`=0; then `OPS_A`=1.
- Contention: `A_VALID` and `B_VALID` held high from reset with B_SEL=0, B_X=6, B_Y=2 -> grant order A, B, A, B; each B response has `RESP_OUT`=4 and `RESP_ID`=1; `OPS_A` and `OPS_B` stay within 1 of each other.
- Backpressure: `RESP_READY`=0 for 10 cycles after `RESP_VALID` rises, with A/B operands toggling -> `RESP_OUT`/`RESP_ID` stable, both READYs 0, counters unchanged; the response completes on the first cycle `RESP_READY`=1.
- Opcode sweep, n=4: for every SEL 0–7 with X=-8, Y=7 and with X=4'b1010, Y=4'b0110 -> `RESP_OUT` equals a standalone ALU reference instance driven with the same inputs; SEL=3 with X=-8, Y=7 gives -11.
- Reset mid-operation: `RST` pulsed while in EXEC, and again while in RESP -> the next cycle has `RESP_VALID`=0, counters 0 and `PRIO`=0; no response is emitted for the discarded request.
- Counter wrap: 256 A completions -> `OPS_A` reads 255 then 0; `OPS_B` stays unchanged.

Source files
------------

// File: rtl/alu_rr_scheduler_1210733.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler_1210733
//
// Round-robin front end that shares one ALU_structural_1210733 between two
// requesters (A and B). A granted request is latched into operand registers,
// evaluated by the ALU for one cycle (EXEC), and its registered result is held
// on a single response channel tagged with the requester ID until the
// consumer accepts it (RESP). After each completed response the served
// requester drops to low priority.
//
// Ports
//   CLK, RST                    clock, synchronous active-high reset
//   A_VALID/A_X/A_Y/A_SEL       request from A (signed operands, 3-bit opcode)
//   A_READY                     A's request is accepted this cycle
//   B_*                         same for requester B
//   RESP_VALID/RESP_ID/RESP_OUT response channel (ID 0 = A, 1 = B)
//   RESP_READY                  consumer accepts the response
//   OPS_A, OPS_B                completed responses per requester (mod 256)
// ---------------------------------------------------------------------------

// Shared ALU: signed n-bit operands, signed n+2-bit result.
// Halving is an arithmetic right shift (rounds toward -inf); the logic ops are
// evaluated on the sign-extended operands, which equals sign-extending the
// n-bit logic result.
module ALU_structural_1210733 #(
  parameter int n = 4
) (
  input  logic signed [n-1:0] X,
  input  logic signed [n-1:0] Y,
  input  logic        [2:0]   SEL,
  output logic signed [n+1:0] OUT
);

  logic signed [n+1:0] xe, ye, sum;

  assign xe  = X;
  assign ye  = Y;
  assign sum = xe + ye;

  always_comb begin
    OUT = '0;
    case (SEL)
      3'd0:    OUT = sum >>> 1;
      3'd1:    OUT = sum <<< 1;
      3'd2:    OUT = (xe >>> 1) + ye;
      3'd3:    OUT = xe - (ye >>> 1);
      3'd4:    OUT = ~(xe & ye);
      3'd5:    OUT = ~xe;
      3'd6:    OUT = ~(xe | ye);
      default: OUT = xe ^ ye;
    endcase
  end

endmodule

module alu_rr_scheduler_1210733 #(
  parameter int n = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                A_VALID,
  input  logic signed [n-1:0] A_X,
  input  logic signed [n-1:0] A_Y,
  input  logic        [2:0]   A_SEL,
  output logic                A_READY,
  input  logic                B_VALID,
  input  logic signed [n-1:0] B_X,
  input  logic signed [n-1:0] B_Y,
  input  logic        [2:0]   B_SEL,
  output logic                B_READY,
  output logic                RESP_VALID,
  output logic                RESP_ID,
  output logic signed [n+1:0] RESP_OUT,
  input  logic                RESP_READY,
  output logic        [7:0]   OPS_A,
  output logic        [7:0]   OPS_B
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q, state_d;
  logic                prio_q, prio_d;
  logic signed [n-1:0] opx_q, opx_d, opy_q, opy_d;
  logic        [2:0]   opsel_q, opsel_d;
  logic                opid_q, opid_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_id_q, resp_id_d;
  logic signed [n+1:0] resp_out_q, resp_out_d;
  logic        [7:0]   ops_a_q, ops_a_d, ops_b_q, ops_b_d;
  logic signed [n+1:0] alu_out;
  logic                grant_b, a_ready, b_ready;

  // B wins when it is the only requester, or when both ask and B holds priority.
  assign grant_b = B_VALID & (~A_VALID | prio_q);
  // Readies are masked during reset so no handshake is seen on a reset edge.
  assign a_ready = (state_q == IDLE) & ~RST & A_VALID & ~grant_b;
  assign b_ready = (state_q == IDLE) & ~RST & grant_b;

  ALU_structural_1210733 #(.n(n)) u_alu (
    .X   (opx_q),
    .Y   (opy_q),
    .SEL (opsel_q),
    .OUT (alu_out)
  );

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    opx_d        = opx_q;
    opy_d        = opy_q;
    opsel_d      = opsel_q;
    opid_d       = opid_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_out_d   = resp_out_q;
    ops_a_d      = ops_a_q;
    ops_b_d      = ops_b_q;
    case (state_q)
      IDLE: begin
        if (a_ready) begin
          opx_d   = A_X;
          opy_d   = A_Y;
          opsel_d = A_SEL;
          opid_d  = 1'b0;
          state_d = EXEC;
        end else if (b_ready) begin
          opx_d   = B_X;
          opy_d   = B_Y;
          opsel_d = B_SEL;
          opid_d  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        resp_out_d   = alu_out;
        resp_id_d    = opid_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (RESP_READY) begin
          resp_valid_d = 1'b0;
          if (resp_id_q) ops_b_d = ops_b_q + 8'd1;
          else           ops_a_d = ops_a_q + 8'd1;
          // The requester just served yields priority to the other one.
          prio_d  = ~resp_id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      opx_q        <= '0;
      opy_q        <= '0;
      opsel_q      <= '0;
      opid_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_out_q   <= '0;
      ops_a_q      <= '0;
      ops_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      opx_q        <= opx_d;
      opy_q        <= opy_d;
      opsel_q      <= opsel_d;
      opid_q       <= opid_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_out_q   <= resp_out_d;
      ops_a_q      <= ops_a_d;
      ops_b_q      <= ops_b_d;
    end
  end

  assign A_READY    = a_ready;
  assign B_READY    = b_ready;
  assign RESP_VALID = resp_valid_q;
  assign RESP_ID    = resp_id_q;
  assign RESP_OUT   = resp_out_q;
  assign OPS_A      = ops_a_q;
  assign OPS_B      = ops_b_q;

endmodule

// File: tb/tb_alu_rr_scheduler_1210733.sv
module tb_alu_rr_scheduler_1210733;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              A_VALID = 1'b0, B_VALID = 1'b0;
  logic signed [3:0] A_X = '0, A_Y = '0, B_X = '0, B_Y = '0;
  logic        [2:0] A_SEL = '0, B_SEL = '0;
  logic              A_READY, B_READY;
  logic              RESP_VALID, RESP_ID;
  logic signed [5:0] RESP_OUT;
  logic              RESP_READY = 1'b0;
  logic        [7:0] OPS_A, OPS_B;

  int errors = 0;
  int checks = 0;

  alu_rr_scheduler_1210733 #(.n(4)) dut (
    .CLK(CLK), .RST(RST),
    .A_VALID(A_VALID), .A_X(A_X), .A_Y(A_Y), .A_SEL(A_SEL), .A_READY(A_READY),
    .B_VALID(B_VALID), .B_X(B_X), .B_Y(B_Y), .B_SEL(B_SEL), .B_READY(B_READY),
    .RESP_VALID(RESP_VALID), .RESP_ID(RESP_ID), .RESP_OUT(RESP_OUT),
    .RESP_READY(RESP_READY), .OPS_A(OPS_A), .OPS_B(OPS_B)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference arithmetic: halving rounds toward minus infinity; logic ops on
  // sign-extended values. All results fit the 6-bit output range for n=4.
  function automatic int ref_alu(input int x, input int y, input int sel);
    int r;
    case (sel)
      0: r = (x + y) >>> 1;
      1: r = 2 * (x + y);
      2: r = (x >>> 1) + y;
      3: r = x - (y >>> 1);
      4: r = ~(x & y);
      5: r = ~x;
      6: r = ~(x | y);
      default: r = x ^ y;
    endcase
    return r;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // One complete transaction from a single requester with RESP_READY high.
  task automatic do_txn(input bit id, input logic signed [3:0] x, input logic signed [3:0] y,
                        input logic [2:0] sel, output int out, output int oid, output bit ok);
    int w;
    ok = 1'b0; out = 0; oid = 0;
    if (id) begin B_VALID = 1'b1; B_X = x; B_Y = y; B_SEL = sel; A_VALID = 1'b0; end
    else    begin A_VALID = 1'b1; A_X = x; A_Y = y; A_SEL = sel; B_VALID = 1'b0; end
    RESP_READY = 1'b1;
    #1;
    w = 0;
    while (!(id ? B_READY : A_READY) && w < 10) begin @(negedge CLK); #1; w++; end
    if (w >= 10) begin A_VALID = 1'b0; B_VALID = 1'b0; return; end
    @(posedge CLK); #1;
    A_VALID = 1'b0; B_VALID = 1'b0;
    w = 0;
    while (!RESP_VALID && w < 10) begin @(negedge CLK); w++; end
    if (w >= 10) return;
    out = int'(RESP_OUT); oid = int'(RESP_ID);
    @(posedge CLK);
    @(negedge CLK);
    ok = 1'b1;
  endtask

  typedef struct {
    bit                id;
    logic [2:0]        sel;
    logic signed [3:0] x;
    logic signed [3:0] y;
    int                exp;
  } vec_t;

  vec_t vecs[16];
  int   e1[8] = '{-1, -2, 3, -11, -1, 7, 0, -1};
  int   e2[8] = '{0, 0, 3, -9, -3, 5, 1, -4};

  initial begin
    int  out, oid, w, pa, pb, saved_out, saved_id;
    bit  ok, seen, ea, eb;
    int  grants[$];
    int  bresp;
    bit  busy; int age; int eid; int eout; int mprio; int mops[2];

    // ---------------- reset state ----------------
    A_VALID = 1'b1; B_VALID = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rst_a_ready", int'(A_READY), 0);
    chk("rst_b_ready", int'(B_READY), 0);
    @(posedge CLK); @(negedge CLK);
    A_VALID = 1'b0; B_VALID = 1'b0;
    chk("rst_resp_valid", int'(RESP_VALID), 0);
    chk("rst_resp_id", int'(RESP_ID), 0);
    chk("rst_resp_out", int'(RESP_OUT), 0);
    chk("rst_ops_a", int'(OPS_A), 0);
    chk("rst_ops_b", int'(OPS_B), 0);
    RST = 1'b0;

    // ---------------- single request ----------------
    @(negedge CLK);
    A_VALID = 1'b1; A_SEL = 3'd1; A_X = 4'sd3; A_Y = 4'sd2; RESP_READY = 1'b1;
    #1;
    chk("single_a_ready", int'(A_READY), 1);
    @(posedge CLK); #1; A_VALID = 1'b0;
    @(negedge CLK);
    chk("single_exec_valid", int'(RESP_VALID), 0);
    @(negedge CLK);
    chk("single_resp_valid", int'(RESP_VALID), 1);
    chk("single_resp_out", int'(RESP_OUT), 10);
    chk("single_resp_id", int'(RESP_ID), 0);
    @(negedge CLK);
    chk("single_done_valid", int'(RESP_VALID), 0);
    chk("single_ops_a", int'(OPS_A), 1);

    // ---------------- opcode sweep (table) ----------------
    for (int s = 0; s < 8; s++) begin
      vecs[s]     = '{id: 1'(s % 2), sel: 3'(s), x: -4'sd8, y: 4'sd7, exp: e1[s]};
      vecs[s + 8] = '{id: 1'((s + 1) % 2), sel: 3'(s), x: 4'b1010, y: 4'b0110, exp: e2[s]};
    end
    for (int i = 0; i < 16; i++) begin
      do_txn(vecs[i].id, vecs[i].x, vecs[i].y, vecs[i].sel, out, oid, ok);
      chk($sformatf("vec%0d_done", i), int'(ok), 1);
      chk($sformatf("vec%0d_out", i), out, vecs[i].exp);
      chk($sformatf("vec%0d_id", i), oid, int'(vecs[i].id));
    end

    // ---------------- backpressure ----------------
    pa = int'(OPS_A); pb = int'(OPS_B);
    A_VALID = 1'b1; A_SEL = 3'd2; A_X = 4'sd5; A_Y = -4'sd3; RESP_READY = 1'b0;
    #1;
    w = 0;
    while (!A_READY && w < 10) begin @(negedge CLK); #1; w++; end
    chk("bp_grant", int'(w < 10), 1);
    @(posedge CLK); #1; A_VALID = 1'b0;
    w = 0;
    while (!RESP_VALID && w < 10) begin @(negedge CLK); w++; end
    chk("bp_resp_rise", int'(RESP_VALID), 1);
    chk("bp_out", int'(RESP_OUT), -1);
    saved_out = int'(RESP_OUT); saved_id = int'(RESP_ID);
    for (int c = 0; c < 10; c++) begin
      A_VALID = 1'b1; B_VALID = 1'b1;
      A_X = 4'($urandom); B_X = 4'($urandom); A_SEL = 3'($urandom); B_SEL = 3'($urandom);
      #1;
      chk("bp_valid_hold", int'(RESP_VALID), 1);
      chk("bp_out_hold", int'(RESP_OUT), saved_out);
      chk("bp_id_hold", int'(RESP_ID), saved_id);
      chk("bp_ready_a", int'(A_READY), 0);
      chk("bp_ready_b", int'(B_READY), 0);
      chk("bp_ops_a", int'(OPS_A), pa);
      @(negedge CLK);
    end
    A_VALID = 1'b0; B_VALID = 1'b0; RESP_READY = 1'b1;
    @(negedge CLK);
    chk("bp_release_valid", int'(RESP_VALID), 0);
    chk("bp_release_ops_a", int'(OPS_A), (pa + 1) % 256);
    chk("bp_release_ops_b", int'(OPS_B), pb);

    // ---------------- contention ----------------
    A_VALID = 1'b1; A_SEL = 3'd7; A_X = 4'sd5; A_Y = 4'sd3;
    B_VALID = 1'b1; B_SEL = 3'd0; B_X = 4'sd6; B_Y = 4'sd2;
    RESP_READY = 1'b1;
    do_reset();
    grants.delete();
    bresp = 0;
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      #1;
      if (A_READY) grants.push_back(0);
      else if (B_READY) grants.push_back(1);
      if (RESP_VALID && RESP_ID) begin
        bresp++;
        chk("cont_b_out", int'(RESP_OUT), 4);
      end
      chk("cont_balance", int'(((int'(OPS_A) - int'(OPS_B)) <= 1) && ((int'(OPS_B) - int'(OPS_A)) <= 1)), 1);
      @(negedge CLK);
    end
    chk("cont_grants", grants.size(), 4);
    if (grants.size() == 4)
      for (int i = 0; i < 4; i++) chk($sformatf("cont_order%0d", i), grants[i], i % 2);
    chk("cont_b_seen", int'(bresp >= 1), 1);
    A_VALID = 1'b0; B_VALID = 1'b0;
    repeat (4) @(negedge CLK);

    // ---------------- reset during EXEC ----------------
    do_txn(1'b0, 4'sd1, 4'sd1, 3'd0, out, oid, ok);
    chk("rexec_pre_ops", int'(OPS_A != 0 || OPS_B != 0), 1);
    A_VALID = 1'b1; A_X = 4'sd2; A_SEL = 3'd1;
    #1;
    chk("rexec_grant", int'(A_READY), 1);
    @(posedge CLK); #1;
    A_VALID = 1'b0; RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("rexec_valid", int'(RESP_VALID), 0);
    chk("rexec_ops_a", int'(OPS_A), 0);
    chk("rexec_ops_b", int'(OPS_B), 0);
    A_VALID = 1'b1; B_VALID = 1'b1;
    #1;
    chk("rexec_prio_a", int'(A_READY), 1);
    chk("rexec_prio_b", int'(B_READY), 0);
    A_VALID = 1'b0; B_VALID = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(negedge CLK); if (RESP_VALID) seen = 1'b1; end
    chk("rexec_no_resp", int'(seen), 0);

    // ---------------- reset during RESP ----------------
    do_txn(1'b0, 4'sd1, 4'sd1, 3'd0, out, oid, ok);
    A_VALID = 1'b1; A_X = 4'sd3; A_SEL = 3'd1; RESP_READY = 1'b0;
    #1;
    chk("rresp_grant", int'(A_READY), 1);
    @(posedge CLK); #1; A_VALID = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("rresp_in_resp", int'(RESP_VALID), 1);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0; RESP_READY = 1'b1;
    chk("rresp_valid", int'(RESP_VALID), 0);
    chk("rresp_ops_a", int'(OPS_A), 0);
    chk("rresp_out", int'(RESP_OUT), 0);
    A_VALID = 1'b1; B_VALID = 1'b1;
    #1;
    chk("rresp_prio_a", int'(A_READY), 1);
    A_VALID = 1'b0; B_VALID = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(negedge CLK); if (RESP_VALID) seen = 1'b1; end
    chk("rresp_no_resp", int'(seen), 0);

    // ---------------- randomized against transaction model ----------------
    do_reset();
    busy = 1'b0; age = 0; eid = 0; eout = 0; mprio = 0; mops[0] = 0; mops[1] = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      A_VALID = 1'($urandom); B_VALID = 1'($urandom);
      A_X = 4'($urandom); A_Y = 4'($urandom); A_SEL = 3'($urandom);
      B_X = 4'($urandom); B_Y = 4'($urandom); B_SEL = 3'($urandom);
      RESP_READY = ($urandom_range(0, 3) != 0);
      #1;
      ea = !busy && A_VALID && (!B_VALID || mprio == 0);
      eb = !busy && B_VALID && (!A_VALID || mprio == 1);
      chk("rnd_a_ready", int'(A_READY), int'(ea));
      chk("rnd_b_ready", int'(B_READY), int'(eb));
      chk("rnd_resp_valid", int'(RESP_VALID), int'(busy && age >= 1));
      if (busy && age >= 1) begin
        chk("rnd_resp_out", int'(RESP_OUT), eout);
        chk("rnd_resp_id", int'(RESP_ID), eid);
      end
      chk("rnd_ops_a", int'(OPS_A), mops[0]);
      chk("rnd_ops_b", int'(OPS_B), mops[1]);
      @(posedge CLK);
      if (ea) begin
        busy = 1'b1; age = 0; eid = 0; eout = ref_alu(int'(A_X), int'(A_Y), int'(A_SEL));
      end else if (eb) begin
        busy = 1'b1; age = 0; eid = 1; eout = ref_alu(int'(B_X), int'(B_Y), int'(B_SEL));
      end else if (busy) begin
        if (age >= 1 && RESP_READY) begin
          busy = 1'b0;
          mops[eid] = (mops[eid] + 1) % 256;
          mprio = 1 - eid;
        end else begin
          age++;
        end
      end
    end
    A_VALID = 1'b0; B_VALID = 1'b0;

    // ---------------- counter wrap ----------------
    do_reset();
    for (int i = 0; i < 256; i++) begin
      do_txn(1'b0, 4'($urandom), 4'($urandom), 3'($urandom), out, oid, ok);
      if (!ok) chk($sformatf("wrap_txn%0d", i), int'(ok), 1);
      if (i == 254) chk("wrap_255", int'(OPS_A), 255);
    end
    chk("wrap_0", int'(OPS_A), 0);
    chk("wrap_ops_b", int'(OPS_B), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
